// File: rtl/img_io_sequencer_pkg.sv
// Shared types for the image I/O sequencer: command codes, FSM states
// and the single-port image SRAM control bundle.
package img_io_sequencer_pkg;

    typedef enum logic [1:0] {
        CMD_NOP,
        CMD_LOAD,
        CMD_PROC,
        CMD_DUMP
    } io_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_RUN,
        S_DONE
    } seq_state_t;

    typedef struct packed {
        logic        en;
        logic        we;
        logic [13:0] addr;
        logic [7:0]  wdata;
    } img_sram_ctrl_t;

    localparam img_sram_ctrl_t IMG_SRAM_CTRL_IDLE = '0;

endpackage

// File: rtl/img_io_sequencer_if.sv
// Command channel into the sequencer: one command with image dimensions,
// accepted on cmd_valid && cmd_ready.
interface img_io_sequencer_if;
    import img_io_sequencer_pkg::*;

    logic       cmd_valid;
    io_cmd_t    cmd;
    logic [7:0] cmd_nrows;
    logic [7:0] cmd_ncols;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd,
        output cmd_nrows,
        output cmd_ncols,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd,
        input  cmd_nrows,
        input  cmd_ncols,
        output cmd_ready
    );

endinterface

// File: rtl/img_sram_port_mux.sv
// Owner-select mux for the shared SRAM port; with no owner the port is
// held at the no-access value.
module img_sram_port_mux
    import img_io_sequencer_pkg::*;
(
    input  io_cmd_t        owner,
    input  img_sram_ctrl_t rx_ctrl,
    input  img_sram_ctrl_t proc_ctrl,
    input  img_sram_ctrl_t tx_ctrl,
    output img_sram_ctrl_t sram_ctrl
);

    always_comb begin
        sram_ctrl = IMG_SRAM_CTRL_IDLE;
        case (owner)
            CMD_LOAD: sram_ctrl = rx_ctrl;
            CMD_PROC: sram_ctrl = proc_ctrl;
            CMD_DUMP: sram_ctrl = tx_ctrl;
            default:  sram_ctrl = IMG_SRAM_CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/img_io_sequencer.sv
// Sequencer that launches rx/proc/tx blocks one at a time, arbitrates the
// image SRAM port to the active block and reports run length and timeouts.
module img_io_sequencer
    import img_io_sequencer_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 16,
    parameter int TO_W         = $clog2(BUSY_TIMEOUT + 1),
    parameter int CYC_W        = 24
) (
    input  logic               clk,
    input  logic               rstn,
    img_io_sequencer_if.slave  cmd_bus,
    output logic [7:0]         nrows,
    output logic [7:0]         ncols,
    output logic               rx_en,
    output logic               proc_en,
    output logic               tx_en,
    input  logic               rx_busy,
    input  logic               proc_busy,
    input  logic               tx_busy,
    input  img_sram_ctrl_t     rx_sram_ctrl,
    input  img_sram_ctrl_t     proc_sram_ctrl,
    input  img_sram_ctrl_t     tx_sram_ctrl,
    output img_sram_ctrl_t     sram_ctrl,
    output logic               done,
    output logic               err,
    output logic [CYC_W-1:0]   op_cycles
);

    seq_state_t      state;
    io_cmd_t         owner;
    logic [TO_W-1:0] to_cnt;
    logic            owner_busy;
    logic            accept;

    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (&v) ? v : v + CYC_W'(1);
    endfunction

    assign cmd_bus.cmd_ready = (state == S_IDLE);
    assign accept = (state == S_IDLE) && cmd_bus.cmd_valid && (cmd_bus.cmd != CMD_NOP);

    // Only the current owner's busy is observed; the others are ignored.
    always_comb begin
        owner_busy = 1'b0;
        case (owner)
            CMD_LOAD: owner_busy = rx_busy;
            CMD_PROC: owner_busy = proc_busy;
            CMD_DUMP: owner_busy = tx_busy;
            default:  owner_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            owner     <= CMD_NOP;
            to_cnt    <= '0;
            rx_en     <= 1'b0;
            proc_en   <= 1'b0;
            tx_en     <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            op_cycles <= '0;
            nrows     <= '0;
            ncols     <= '0;
        end else begin
            rx_en   <= 1'b0;
            proc_en <= 1'b0;
            tx_en   <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        nrows     <= cmd_bus.cmd_nrows;
                        ncols     <= cmd_bus.cmd_ncols;
                        owner     <= cmd_bus.cmd;
                        err       <= 1'b0;
                        op_cycles <= '0;
                        rx_en     <= (cmd_bus.cmd == CMD_LOAD);
                        proc_en   <= (cmd_bus.cmd == CMD_PROC);
                        tx_en     <= (cmd_bus.cmd == CMD_DUMP);
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    to_cnt <= '0;
                    state  <= S_WAIT_BUSY;
                end
                // Busy takes priority over the final timeout count.
                S_WAIT_BUSY: begin
                    if (owner_busy) begin
                        state <= S_RUN;
                    end else if (to_cnt == TO_W'(BUSY_TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_RUN: begin
                    op_cycles <= sat_inc(op_cycles);
                    if (!owner_busy) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                // Ownership is held through DONE so the last write-back lands.
                S_DONE: begin
                    owner <= CMD_NOP;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    img_sram_port_mux u_port_mux (
        .owner     (owner),
        .rx_ctrl   (rx_sram_ctrl),
        .proc_ctrl (proc_sram_ctrl),
        .tx_ctrl   (tx_sram_ctrl),
        .sram_ctrl (sram_ctrl)
    );

endmodule

// File: tb/tb_img_io_sequencer.sv
// Bench for img_io_sequencer: table of operations, randomized operations
// against a timing model, plus reset, NOP and saturation sequences.
module tb_img_io_sequencer;
    import img_io_sequencer_pkg::*;

    localparam int BT    = 16;
    localparam int CYC_W = 24;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    img_io_sequencer_if cmd_if();
    logic [7:0]       nrows, ncols;
    logic             rx_en, proc_en, tx_en;
    logic             rx_busy, proc_busy, tx_busy;
    img_sram_ctrl_t   rx_ctrl, proc_ctrl, tx_ctrl, sram_ctrl;
    logic             done, err;
    logic [CYC_W-1:0] op_cycles;

    img_io_sequencer #(.BUSY_TIMEOUT(BT), .CYC_W(CYC_W)) dut (
        .clk(clk), .rstn(rstn), .cmd_bus(cmd_if),
        .nrows(nrows), .ncols(ncols),
        .rx_en(rx_en), .proc_en(proc_en), .tx_en(tx_en),
        .rx_busy(rx_busy), .proc_busy(proc_busy), .tx_busy(tx_busy),
        .rx_sram_ctrl(rx_ctrl), .proc_sram_ctrl(proc_ctrl), .tx_sram_ctrl(tx_ctrl),
        .sram_ctrl(sram_ctrl), .done(done), .err(err), .op_cycles(op_cycles)
    );

    img_io_sequencer_if s_if();
    logic           s_busy;
    logic [7:0]     s_nrows, s_ncols;
    logic           s_rx_en, s_proc_en, s_tx_en;
    img_sram_ctrl_t s_sram;
    logic           s_done, s_err;
    logic [3:0]     s_op;

    img_io_sequencer #(.BUSY_TIMEOUT(BT), .CYC_W(4)) u_sat (
        .clk(clk), .rstn(rstn), .cmd_bus(s_if),
        .nrows(s_nrows), .ncols(s_ncols),
        .rx_en(s_rx_en), .proc_en(s_proc_en), .tx_en(s_tx_en),
        .rx_busy(1'b0), .proc_busy(s_busy), .tx_busy(1'b0),
        .rx_sram_ctrl(IMG_SRAM_CTRL_IDLE), .proc_sram_ctrl(IMG_SRAM_CTRL_IDLE),
        .tx_sram_ctrl(IMG_SRAM_CTRL_IDLE),
        .sram_ctrl(s_sram), .done(s_done), .err(s_err), .op_cycles(s_op)
    );

    typedef struct {
        io_cmd_t    cmd;
        logic [7:0] nr;
        logic [7:0] nc;
        int         dly;
        int         len;
        bit         hold;
        int         exp_done;
        bit         exp_err;
        int         exp_op;
    } op_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Timing model: busy is low for dly cycles after the enable cycle, then high for len cycles.
    function automatic op_t model(input op_t o);
        op_t r = o;
        if (o.len == 0 || o.dly >= BT) begin
            r.exp_done = BT + 1;
            r.exp_err  = 1'b1;
            r.exp_op   = 0;
        end else begin
            r.exp_done = o.dly + o.len + 2;
            r.exp_err  = 1'b0;
            r.exp_op   = o.len;
        end
        return r;
    endfunction

    function automatic logic [2:0] onehot(input io_cmd_t c);
        case (c)
            CMD_LOAD: return 3'b100;
            CMD_PROC: return 3'b010;
            CMD_DUMP: return 3'b001;
            default:  return 3'b000;
        endcase
    endfunction

    function automatic img_sram_ctrl_t exp_ctrl(input io_cmd_t c);
        case (c)
            CMD_LOAD: return rx_ctrl;
            CMD_PROC: return proc_ctrl;
            CMD_DUMP: return tx_ctrl;
            default:  return IMG_SRAM_CTRL_IDLE;
        endcase
    endfunction

    task automatic drive_cycle(input io_cmd_t own, input logic own_busy);
        rx_ctrl   = img_sram_ctrl_t'(24'($urandom));
        proc_ctrl = img_sram_ctrl_t'(24'($urandom));
        tx_ctrl   = img_sram_ctrl_t'(24'($urandom));
        rx_busy   = 1'($urandom);
        proc_busy = 1'($urandom);
        tx_busy   = 1'($urandom);
        case (own)
            CMD_LOAD: rx_busy   = own_busy;
            CMD_PROC: proc_busy = own_busy;
            CMD_DUMP: tx_busy   = own_busy;
            default: ;
        endcase
    endtask

    task automatic run_op(input op_t o, input string tag);
        chk({tag, ".ready_before"}, cmd_if.cmd_ready, 1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd       = o.cmd;
        cmd_if.cmd_nrows = o.nr;
        cmd_if.cmd_ncols = o.nc;
        tick();
        for (int c = 0; c <= o.exp_done; c++) begin
            if (!o.hold || c == o.exp_done) cmd_if.cmd_valid = 1'b0;
            drive_cycle(o.cmd, (c >= o.dly + 1) && (c <= o.dly + o.len));
            #1;
            chk({tag, ".en"}, {rx_en, proc_en, tx_en}, (c == 0) ? onehot(o.cmd) : 3'b000);
            chk({tag, ".ready"}, cmd_if.cmd_ready, 0);
            chk({tag, ".done"}, done, (c == o.exp_done) ? 1 : 0);
            chk({tag, ".err"}, err, (c == o.exp_done) ? o.exp_err : 1'b0);
            chk({tag, ".sram"}, sram_ctrl, exp_ctrl(o.cmd));
            if (c == 0) begin
                chk({tag, ".nrows"}, nrows, o.nr);
                chk({tag, ".ncols"}, ncols, o.nc);
                chk({tag, ".op_clr"}, op_cycles, 0);
            end
            if (c == o.exp_done) chk({tag, ".op_cycles"}, op_cycles, o.exp_op);
            tick();
        end
        drive_cycle(CMD_NOP, 1'b0);
        #1;
        chk({tag, ".ready_after"}, cmd_if.cmd_ready, 1);
        chk({tag, ".done_after"}, done, 0);
        chk({tag, ".err_sticky"}, err, o.exp_err);
        chk({tag, ".op_hold"}, op_cycles, o.exp_op);
        chk({tag, ".sram_idle"}, sram_ctrl, IMG_SRAM_CTRL_IDLE);
        chk({tag, ".ncols_hold"}, ncols, o.nc);
    endtask

    op_t tbl[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        op_t o;
        int  done_at;

        tbl[0] = '{CMD_LOAD, 8'd128, 8'd128, 0,  40, 1'b0, 42, 1'b0, 40};
        tbl[1] = '{CMD_DUMP, 8'd128, 8'd128, 3,  30, 1'b0, 35, 1'b0, 30};
        tbl[2] = '{CMD_PROC, 8'd16,  8'd16,  99, 0,  1'b0, 17, 1'b1, 0};
        tbl[3] = '{CMD_LOAD, 8'd1,   8'd255, 15, 3,  1'b0, 20, 1'b0, 3};
        tbl[4] = '{CMD_DUMP, 8'd200, 8'd7,   2,  5,  1'b1, 9,  1'b0, 5};
        tbl[5] = '{CMD_PROC, 8'd255, 8'd1,   14, 1,  1'b0, 17, 1'b0, 1};
        tbl[6] = '{CMD_LOAD, 8'd9,   8'd10,  16, 4,  1'b0, 17, 1'b1, 0};

        rstn = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd       = CMD_NOP;
        cmd_if.cmd_nrows = '0;
        cmd_if.cmd_ncols = '0;
        s_if.cmd_valid   = 1'b0;
        s_if.cmd         = CMD_NOP;
        s_if.cmd_nrows   = '0;
        s_if.cmd_ncols   = '0;
        s_busy           = 1'b0;
        drive_cycle(CMD_NOP, 1'b0);
        #12;
        chk("reset.ready", cmd_if.cmd_ready, 1);
        chk("reset.en", {rx_en, proc_en, tx_en}, 3'b000);
        chk("reset.done_err", {done, err}, 2'b00);
        chk("reset.op_cycles", op_cycles, 0);
        chk("reset.dims", {nrows, ncols}, 16'h0);
        chk("reset.sram", sram_ctrl, IMG_SRAM_CTRL_IDLE);
        tick();
        rstn = 1'b1;
        tick();

        // NOP with valid is ignored.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd       = CMD_NOP;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(CMD_NOP, 1'b0);
            tick();
            chk("nop.ready", cmd_if.cmd_ready, 1);
            chk("nop.en", {rx_en, proc_en, tx_en}, 3'b000);
            chk("nop.sram", sram_ctrl, IMG_SRAM_CTRL_IDLE);
        end
        cmd_if.cmd_valid = 1'b0;

        for (int i = 0; i < 7; i++) run_op(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 30; i++) begin
            o.cmd  = io_cmd_t'(2'(1 + $urandom % 3));
            o.nr   = 8'($urandom);
            o.nc   = 8'($urandom);
            o.dly  = int'($urandom % 20);
            o.len  = 1 + int'($urandom % 25);
            o.hold = 1'($urandom);
            run_op(model(o), $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a DUMP run.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd       = CMD_DUMP;
        cmd_if.cmd_nrows = 8'd9;
        cmd_if.cmd_ncols = 8'd9;
        tick();
        cmd_if.cmd_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive_cycle(CMD_DUMP, c >= 1);
            tick();
        end
        drive_cycle(CMD_DUMP, 1'b1);
        #1;
        chk("midrun.sram_owned", sram_ctrl, tx_ctrl);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrun.ready", cmd_if.cmd_ready, 1);
        chk("midrun.en", {rx_en, proc_en, tx_en}, 3'b000);
        chk("midrun.done_err", {done, err}, 2'b00);
        chk("midrun.op_cycles", op_cycles, 0);
        chk("midrun.dims", {nrows, ncols}, 16'h0);
        chk("midrun.sram", sram_ctrl, IMG_SRAM_CTRL_IDLE);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        run_op(tbl[0], "after_reset");

        // Saturating run-length counter on the 4-bit build.
        s_if.cmd_valid = 1'b1;
        s_if.cmd       = CMD_PROC;
        s_if.cmd_nrows = 8'd3;
        s_if.cmd_ncols = 8'd4;
        tick();
        s_if.cmd_valid = 1'b0;
        done_at = -1;
        for (int c = 0; c <= 30; c++) begin
            s_busy = (c >= 1) && (c <= 21);
            #1;
            if (c == 0) begin
                chk("sat.en", {s_rx_en, s_proc_en, s_tx_en}, 3'b010);
                chk("sat.dims", {s_nrows, s_ncols}, {8'd3, 8'd4});
            end
            if (c == 22) chk("sat.op_mid", s_op, 4'd15);
            if (s_done && done_at < 0) done_at = c;
            tick();
        end
        chk("sat.done_cycle", done_at, 23);
        chk("sat.op_final", s_op, 4'd15);
        chk("sat.err", s_err, 0);
        chk("sat.sram", s_sram, IMG_SRAM_CTRL_IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/img_io_sequencer.md
Name: img_io_sequencer

Overview:
- Hardware initiator for the en/busy handshake of io_rx_controller, io_tx_controller and the convolution engine.
- Accepts one command at a time: LOAD, PROC or DUMP.
- For each command it pulses the selected block's enable, grants that block exclusive ownership of the single img_sram_4_64 port, and waits for the block's busy to fall.
- It also latches the image dimensions, measures run length and flags blocks that never start.

Parameters:
- BUSY_TIMEOUT, 16: cycles allowed after the enable pulse for busy to rise before an error is declared.
- TO_W, $clog2(BUSY_TIMEOUT+1): width of the timeout counter.
- CYC_W, 24: width of the run-length counter.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset. One clock; reset is asynchronous and active-low.
- cmd_valid  in  1  command request.
- cmd  in  2  command code: 1=LOAD, 2=PROC, 3=DUMP, 0=NOP.
- cmd_nrows  in  8  image rows, sampled on command accept.
- cmd_ncols  in  8  image columns, sampled on command accept.
- cmd_ready  out  1  high only in IDLE.
- nrows  out  8  latched rows, fanned out to rx, tx and proc.
- ncols  out  8  latched columns.
- rx_en, proc_en, tx_en  out  1 each  single-cycle start pulses.
- rx_busy, proc_busy, tx_busy  in  1 each  busy from each block.
- rx_sram_ctrl, proc_sram_ctrl, tx_sram_ctrl  in  img_sram_ctrl_t  each requester's SRAM control.
- sram_ctrl  out  img_sram_ctrl_t  to the SRAM.
- done  out  1  one-cycle pulse when an operation completes.
- err  out  1  sticky timeout flag; cleared by the next accepted command.
- op_cycles  out  CYC_W  cycles spent in RUN for the last operation; saturating.

Behaviour:
Reset values (asynchronous, rstn low):
- State IDLE, owner NONE.
- All enables 0, done 0, err 0, op_cycles 0, nrows 0, ncols 0.
- sram_ctrl = IMG_SRAM_CTRL_IDLE.

Command accept:
- A handshake occurs when cmd_valid && cmd_ready && cmd!=0.
- On accept: latch nrows and ncols, set owner from cmd, clear err, clear op_cycles, go to LAUNCH.
- cmd=0 with valid is ignored; the sequencer stays in IDLE.

States:
- IDLE: cmd_ready=1.
- LAUNCH: exactly one cycle. The owner's en=1, the timeout counter is cleared, then go to WAIT_BUSY.
- WAIT_BUSY: busy is first sampled on the cycle after LAUNCH.
  - Owner busy high: go to RUN.
  - Otherwise the counter increments. When it reaches BUSY_TIMEOUT, set err=1 and go to DONE.
  - If busy rises on the same cycle the counter would reach BUSY_TIMEOUT, busy wins: go to RUN, no err.
- RUN: op_cycles increments each cycle, saturating at all-ones. When owner busy is low, go to DONE.
- DONE: done=1 for one cycle, owner returns to NONE, go to IDLE.

SRAM ownership:
- sram_ctrl is a purely combinational mux on the registered owner.
- Owner RX, PROC or TX: sram_ctrl equals that requester's ctrl, from LAUNCH through DONE inclusive, so the final write-back is kept.
- Owner NONE: sram_ctrl = IMG_SRAM_CTRL_IDLE.
- Non-owners' ctrl never reaches the SRAM, even if their busy is high.

Other rules:
- Non-owner busy inputs are ignored.
- Only the owner's en can pulse; never two enables in the same cycle.
- nrows and ncols are stable from the accept cycle until the next accept.
- Reset mid-operation: immediate return to the reset values. The subordinate blocks are reset by their own rstn and are not reset by this block.

Decomposition:
- img_sram_pkg gains:
  - typedef enum logic [1:0] io_cmd_t {CMD_NOP, CMD_LOAD, CMD_PROC, CMD_DUMP};
  - typedef enum for seq_state_t;
  - localparam img_sram_ctrl_t IMG_SRAM_CTRL_IDLE = '0 (no access).
- One sub-module, img_sram_port_mux: a combinational owner-select mux for img_sram_ctrl_t.
- The FSM and counters stay in img_io_sequencer.

Test Plan:
- LOAD 128x128: after reset, cmd=1 with nrows=ncols=128.
  - Expect rx_en high for exactly 1 cycle, 1 cycle after accept.
  - Then stream the 16384 bytes of cat_128_128.bin into rx.
  - Expect sram_ctrl to track rx_sram_ctrl throughout, done once, err=0, op_cycles equal to the rx_busy high duration.
- Round trip: LOAD, then DUMP.
  - tx_en pulses only after done from LOAD.
  - The 16384 captured io_dout bytes are byte-identical to the input file.
  - sram_ctrl never equals tx_sram_ctrl during LOAD.
- Timeout: PROC with proc_busy tied 0.
  - err=1 and done pulse exactly BUSY_TIMEOUT+1 cycles after LAUNCH, then IDLE with cmd_ready=1.
  - The next accepted command clears err.
- Boundary: busy rises on cycle BUSY_TIMEOUT of WAIT_BUSY.
  - Expect RUN and err=0.
  - Separately, cmd_valid held during RUN: cmd_ready=0 and no second enable pulse.
- Reset mid-RUN: deassert rstn during DUMP.
  - Outputs go to reset values asynchronously, before the next clk edge; sram_ctrl = IMG_SRAM_CTRL_IDLE.
  - After release, a fresh LOAD completes normally.
- Saturation: force a 2^CYC_W+5 cycle run with a reduced CYC_W=4 build.
  - op_cycles=15, then done.
